// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the SRAM responder.
// Holds transfer types, size codes, response codes and the alignment rule.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // Sizes above a word can never be aligned, so they fall out as illegal here.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: size_aligned = 1'b1;
            SIZE_HALF: size_aligned = ~lo[0];
            SIZE_WORD: size_aligned = (lo == 2'b00);
            default:   size_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Byte-write strobe decode from captured size and low address bits (little-endian).
// Purely combinational; no latency, no flow control.
module ahb_byte_lane_dec
    import ahb_lite_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb
);

    always_comb begin
        o_strb = 4'b0000;
        case (i_size)
            SIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: o_strb = 4'b1111;
            default:   o_strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: OKAY data phase after WAIT_STATES low cycles, two-cycle ERROR for illegal accesses.
// Reads are served combinationally from the array, so a write committed at one edge is visible to the next data phase.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    slv_state_t      r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            r_dphase, w_dphase_nxt;
    logic            r_write;
    logic [2:0]      r_size;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_lo;
    logic [31:0]     r_mem [MEM_DEPTH];

    htrans_t         w_trans;
    logic [31:0]     w_off;
    logic            w_legal, w_accept, w_capture, w_hreadyout, w_commit;
    logic [3:0]      w_strb;
    logic            w_unused;

    assign w_unused    = ^{HBURST, HPROT, HMASTLOCK};
    assign w_trans     = htrans_t'(HTRANS);
    assign w_off       = HADDR - ADDR_BASE;
    assign w_legal     = (HADDR >= ADDR_BASE) && ({1'b0, w_off} < WIN_BYTES)
                         && size_aligned(HSIZE, HADDR[1:0]);
    assign w_accept    = HSEL && HREADY
                         && (w_trans == TRANS_NONSEQ || w_trans == TRANS_SEQ);
    assign w_hreadyout = !((r_state == ST_WAIT && r_cnt != 4'd0) || r_state == ST_ERR1);

    // Only a legal data phase ever sets r_dphase, so ERROR cycles cannot commit.
    assign w_commit    = r_dphase && r_write && w_hreadyout;

    ahb_byte_lane_dec u_lane_dec (
        .i_size    (r_size),
        .i_addr_lo (r_lo),
        .o_strb    (w_strb)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dphase_nxt = r_dphase;
        w_capture    = 1'b0;
        if (w_hreadyout) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 4'd0;
            w_dphase_nxt = 1'b0;
            if (w_accept) begin
                w_capture = 1'b1;
                if (!w_legal) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_dphase_nxt = 1'b1;
                    if (WS != 4'd0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WS;
                    end
                end
            end
        end else if (r_state == ST_ERR1) begin
            w_state_nxt = ST_ERR2;
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_dphase <= 1'b0;
            r_write  <= 1'b0;
            r_size   <= 3'd0;
            r_idx    <= '0;
            r_lo     <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dphase <= w_dphase_nxt;
            if (w_capture) begin
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_idx   <= w_off[AW+1:2];
                r_lo    <= HADDR[1:0];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = w_hreadyout;
    assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (r_dphase && !r_write && w_hreadyout) ? r_mem[r_idx] : 32'h0;

endmodule
